// File: rtl/game_ctl.sv
// Round/duck sequencer: frame-timed state machine that turns click edges into shots and keeps
// ammo, score, duck and round bookkeeping for the drawing stages.
module game_ctl #(
    parameter int unsigned AMMO            = 3,
    parameter int unsigned START_FRAMES    = 120,
    parameter int unsigned FLY_FRAMES      = 300,
    parameter int unsigned ANIM_FRAMES     = 60,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned MIN_HITS        = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       new_frame_i,
    input  logic       mouse_left_i,
    input  logic       duck_hit_i,
    output logic [2:0] game_state_o,
    output logic       duck_en_o,
    output logic       duck_respawn_o,
    output logic       shot_fire_o,
    output logic [1:0] ammo_o,
    output logic [7:0] score_o,
    output logic [3:0] round_num_o,
    output logic [3:0] duck_cnt_o
);

    localparam int unsigned TimerW = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StFly      = 3'd2,
        StFall     = 3'd3,
        StEscape   = 3'd4,
        StRoundEnd = 3'd5,
        StGameOver = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                mouse_left_q;
    logic [1:0]          ammo_q, ammo_d;
    logic [7:0]          score_q, score_d;
    logic [3:0]          round_q, round_d;
    logic [3:0]          duck_cnt_q, duck_cnt_d;
    logic [3:0]          hits_q, hits_d;
    logic                shot_q, shot_d;
    logic                respawn_q, respawn_d;

    logic click;
    logic start_done, fly_done, anim_done;
    logic [3:0] duck_cnt_inc;

    assign click        = mouse_left_i & ~mouse_left_q;
    assign start_done   = new_frame_i && (timer_q == TimerW'(START_FRAMES - 1));
    assign fly_done     = new_frame_i && (timer_q == TimerW'(FLY_FRAMES - 1));
    assign anim_done    = new_frame_i && (timer_q == TimerW'(ANIM_FRAMES - 1));
    assign duck_cnt_inc = duck_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        timer_d    = new_frame_i ? timer_q + TimerW'(1) : timer_q;
        ammo_d     = ammo_q;
        score_d    = score_q;
        round_d    = round_q;
        duck_cnt_d = duck_cnt_q;
        hits_d     = hits_q;
        shot_d     = 1'b0;
        respawn_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (click) state_d = StStart;
            end
            StStart: begin
                if (start_done) state_d = StFly;
            end
            StFly: begin
                // A shot in the same cycle as the timeout takes priority over the timeout.
                if (click && (ammo_q != 2'd0)) begin
                    shot_d = 1'b1;
                    ammo_d = ammo_q - 2'd1;
                    if (duck_hit_i) begin
                        score_d = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                        hits_d  = hits_q + 4'd1;
                        state_d = StFall;
                    end else if ((ammo_q == 2'd1) || fly_done) begin
                        state_d = StEscape;
                    end
                end else if (fly_done) begin
                    state_d = StEscape;
                end
            end
            StFall, StEscape: begin
                if (anim_done) begin
                    duck_cnt_d = duck_cnt_inc;
                    state_d    = (duck_cnt_inc == 4'(DUCKS_PER_ROUND)) ? StRoundEnd : StFly;
                end
            end
            StRoundEnd: begin
                if (hits_q >= 4'(MIN_HITS)) begin
                    round_d    = (round_q != 4'hF) ? round_q + 4'd1 : round_q;
                    duck_cnt_d = 4'd0;
                    hits_d     = 4'd0;
                    state_d    = StStart;
                end else begin
                    state_d = StGameOver;
                end
            end
            StGameOver: begin
                if (click) begin
                    score_d    = 8'd0;
                    round_d    = 4'd1;
                    duck_cnt_d = 4'd0;
                    hits_d     = 4'd0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) timer_d = '0;

        if ((state_d == StFly) && (state_q != StFly)) begin
            ammo_d    = 2'(AMMO);
            respawn_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            mouse_left_q <= 1'b0;
            ammo_q       <= 2'd0;
            score_q      <= 8'd0;
            round_q      <= 4'd1;
            duck_cnt_q   <= 4'd0;
            hits_q       <= 4'd0;
            shot_q       <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mouse_left_q <= mouse_left_i;
            ammo_q       <= ammo_d;
            score_q      <= score_d;
            round_q      <= round_d;
            duck_cnt_q   <= duck_cnt_d;
            hits_q       <= hits_d;
            shot_q       <= shot_d;
            respawn_q    <= respawn_d;
        end
    end

    assign game_state_o   = state_q;
    assign duck_en_o      = (state_q == StFly);
    assign duck_respawn_o = respawn_q;
    assign shot_fire_o    = shot_q;
    assign ammo_o         = ammo_q;
    assign score_o        = score_q;
    assign round_num_o    = round_q;
    assign duck_cnt_o     = duck_cnt_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed per-cycle vector table for game_ctl with small frame counts, plus a hand-written
// asynchronous-reset-during-FALL sequence.
module tb_game_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_frame, mouse_left, duck_hit;
    logic [2:0] game_state;
    logic       duck_en, duck_respawn, shot_fire;
    logic [1:0] ammo;
    logic [7:0] score;
    logic [3:0] round_num, duck_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_ctl #(
        .AMMO           (3),
        .START_FRAMES   (4),
        .FLY_FRAMES     (8),
        .ANIM_FRAMES    (3),
        .DUCKS_PER_ROUND(2),
        .MIN_HITS       (1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .new_frame_i   (new_frame),
        .mouse_left_i  (mouse_left),
        .duck_hit_i    (duck_hit),
        .game_state_o  (game_state),
        .duck_en_o     (duck_en),
        .duck_respawn_o(duck_respawn),
        .shot_fire_o   (shot_fire),
        .ammo_o        (ammo),
        .score_o       (score),
        .round_num_o   (round_num),
        .duck_cnt_o    (duck_cnt)
    );

    typedef struct {
        logic       nf, ml, dh;
        logic [2:0] st;
        logic [1:0] am;
        logic [7:0] sc;
        logic       sh, rs;
        logic [3:0] dc, rn;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic nf, ml, dh, input logic [2:0] st, input logic [1:0] am,
                     input logic [7:0] sc, input logic sh, rs, input logic [3:0] dc, rn);
        vec_t x;
        x.nf = nf; x.ml = ml; x.dh = dh; x.st = st; x.am = am; x.sc = sc;
        x.sh = sh; x.rs = rs; x.dc = dc; x.rn = rn;
        vecs.push_back(x);
    endtask

    // {state, duck_en, ammo, score, shot, respawn, duck_cnt, round}
    function automatic logic [23:0] pack(input logic [2:0] st, input logic en,
                                         input logic [1:0] am, input logic [7:0] sc,
                                         input logic sh, rs, input logic [3:0] dc, rn);
        return {st, en, am, sc, sh, rs, dc, rn};
    endfunction

    function automatic logic [23:0] actual();
        return pack(game_state, duck_en, ammo, score, shot_fire, duck_respawn, duck_cnt,
                    round_num);
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic nf, ml, dh);
        new_frame = nf; mouse_left = ml; duck_hit = dh;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; new_frame = 1'b0; mouse_left = 1'b0; duck_hit = 1'b0;

        // Round 1: one hit, one three-miss escape.
        v(0,1,0, 1,0,0,0,0, 0,1);
        v(0,0,0, 1,0,0,0,0, 0,1);
        for (int k = 0; k < 3; k++) v(1,0,0, 1,0,0,0,0, 0,1);
        v(1,0,0, 2,3,0,0,1, 0,1);
        v(0,0,0, 2,3,0,0,0, 0,1);
        v(0,1,1, 3,2,1,1,0, 0,1);
        v(0,0,0, 3,2,1,0,0, 0,1);
        v(1,0,0, 3,2,1,0,0, 0,1);
        v(1,0,0, 3,2,1,0,0, 0,1);
        v(1,0,0, 2,3,1,0,1, 1,1);
        v(0,1,0, 2,2,1,1,0, 1,1);
        v(0,0,0, 2,2,1,0,0, 1,1);
        v(0,1,0, 2,1,1,1,0, 1,1);
        v(0,1,0, 2,1,1,0,0, 1,1);
        v(0,0,0, 2,1,1,0,0, 1,1);
        v(0,1,0, 4,0,1,1,0, 1,1);
        v(0,0,0, 4,0,1,0,0, 1,1);
        v(0,1,0, 4,0,1,0,0, 1,1);
        v(0,0,0, 4,0,1,0,0, 1,1);
        v(1,0,0, 4,0,1,0,0, 1,1);
        v(1,0,0, 4,0,1,0,0, 1,1);
        v(1,0,0, 5,0,1,0,0, 2,1);
        v(0,0,0, 1,0,1,0,0, 0,2);
        // Round 2: timeout escape, then a hit on the final FLY frame.
        for (int k = 0; k < 3; k++) v(1,0,0, 1,0,1,0,0, 0,2);
        v(1,0,0, 2,3,1,0,1, 0,2);
        for (int k = 0; k < 7; k++) v(1,0,0, 2,3,1,0,0, 0,2);
        v(1,0,0, 4,3,1,0,0, 0,2);
        v(1,0,0, 4,3,1,0,0, 0,2);
        v(1,0,0, 4,3,1,0,0, 0,2);
        v(1,0,0, 2,3,1,0,1, 1,2);
        for (int k = 0; k < 7; k++) v(1,0,0, 2,3,1,0,0, 1,2);
        v(1,1,1, 3,2,2,1,0, 1,2);
        v(1,0,1, 3,2,2,0,0, 1,2);
        v(1,1,1, 3,2,2,0,0, 1,2);
        v(1,0,0, 5,2,2,0,0, 2,2);
        v(0,0,0, 1,2,2,0,0, 0,3);
        // Round 3: no hits, game over, click back to idle.
        v(1,1,0, 1,2,2,0,0, 0,3);
        v(1,0,0, 1,2,2,0,0, 0,3);
        v(1,0,0, 1,2,2,0,0, 0,3);
        v(1,0,0, 2,3,2,0,1, 0,3);
        for (int k = 0; k < 7; k++) v(1,0,0, 2,3,2,0,0, 0,3);
        v(1,0,0, 4,3,2,0,0, 0,3);
        v(1,0,0, 4,3,2,0,0, 0,3);
        v(1,0,0, 4,3,2,0,0, 0,3);
        v(1,0,0, 2,3,2,0,1, 1,3);
        for (int k = 0; k < 7; k++) v(1,0,0, 2,3,2,0,0, 1,3);
        v(1,0,0, 4,3,2,0,0, 1,3);
        v(1,0,0, 4,3,2,0,0, 1,3);
        v(1,0,0, 4,3,2,0,0, 1,3);
        v(1,0,0, 5,3,2,0,0, 2,3);
        v(0,0,0, 6,3,2,0,0, 2,3);
        v(0,1,0, 0,3,0,0,0, 0,1);
        v(0,0,0, 0,3,0,0,0, 0,1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_state", actual(), pack(3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd1));
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].nf, vecs[i].ml, vecs[i].dh);
            check($sformatf("vec%0d", i), actual(),
                  pack(vecs[i].st, vecs[i].st == 3'd2, vecs[i].am, vecs[i].sc, vecs[i].sh,
                       vecs[i].rs, vecs[i].dc, vecs[i].rn));
        end

        // Async reset while in FALL.
        step(0,1,0);
        step(0,0,0);
        repeat (4) step(1,0,0);
        step(0,1,1);
        check("pre_reset_fall", actual(), pack(3'd3, 1'b0, 2'd2, 8'd1, 1'b1, 1'b0, 4'd0, 4'd1));
        step(1,0,0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", actual(), pack(3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd1));
        step(1,1,1);
        step(0,0,0);
        check("held_reset", actual(), pack(3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd1));
        @(negedge clk);
        rst_n = 1'b1;
        step(0,0,0);
        check("post_reset", actual(), pack(3'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd1));
        step(0,1,0);
        check("post_reset_click", actual(),
              pack(3'd1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctl.md
# game_ctl

Round/duck sequencer for Duck Hunt, in the `clk` domain alongside `vga_timing`. It counts frames from the `new_frame` pulse and turns mouse clicks into shots. It tracks ammo, score, ducks and rounds. It drives the duck/background drawing stages through respawn pulses, an enable and a state code.

## Interface
- `AMMO`, 3: shots loaded at each duck start (1..3).
- `START_FRAMES`, 120: frames spent in START before the first duck of a round.
- `FLY_FRAMES`, 300: frames a duck flies before escaping.
- `ANIM_FRAMES`, 60: frames of FALL or ESCAPE animation.
- `DUCKS_PER_ROUND`, 10: ducks per round (1..15).
- `MIN_HITS`, 6: hits needed to pass a round (≤ `DUCKS_PER_ROUND`).
- `clk`  in  1  65 MHz system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `new_frame`  in  1  one-cycle pulse per frame, from `vga_timing`.
- `mouse_left`  in  1  left-button level, already in the `clk` domain.
- `duck_hit`  in  1  level, cursor over a live duck; sampled only on a click edge.
- `game_state`  out  3  IDLE=0, START=1, FLY=2, FALL=3, ESCAPE=4, ROUND_END=5, GAME_OVER=6.
- `duck_en`  out  1  high only in FLY; duck motion enabled.
- `duck_respawn`  out  1  one-cycle pulse on every entry to FLY.
- `shot_fire`  out  1  one-cycle pulse per accepted shot.
- `ammo`  out  2  shots remaining.
- `score`  out  8  total hits, saturates at 255.
- `round_num`  out  4  current round, starts at 1, saturates at 15.
- `duck_cnt`  out  4  ducks finished in this round.

## Operation
- Click edge: `click = mouse_left & ~mouse_left_q`. `mouse_left_q` resets to 0.
- Frame timer: one shared counter, cleared on every state transition, incremented on `new_frame`.
  - "Timer done" means `new_frame` is high while counter == N−1.
- State machine (all transitions registered):
  - IDLE: on click → START. On entry from GAME_OVER: score=0, round_num=1, duck_cnt=0, hits=0.
  - START: timer done (`START_FRAMES`) → FLY.
  - FLY, entry: ammo=`AMMO`, `duck_respawn` pulses.
  - FLY, click with ammo>0: `shot_fire`, ammo−1.
    - `duck_hit`=1: score+1 (saturating), hits+1 → FALL.
    - Miss that leaves ammo=0 → ESCAPE.
  - FLY, click with ammo=0: ignored, no `shot_fire`.
  - FLY, timer done (`FLY_FRAMES`) → ESCAPE.
  - FALL and ESCAPE: timer done (`ANIM_FRAMES`) → duck_cnt+1.
    - New duck_cnt == `DUCKS_PER_ROUND` → ROUND_END.
    - Otherwise → FLY.
  - ROUND_END, immediate (one cycle):
    - hits ≥ `MIN_HITS`: round_num+1 (saturating), duck_cnt=0, hits=0 → START.
    - Otherwise → GAME_OVER.
  - GAME_OVER: on click → IDLE.
- `hits` is an internal 4-bit counter.
- `duck_en` = (state==FLY). It is decoded from the state register.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - state=IDLE, game_state=0.
  - duck_en=0, duck_respawn=0, shot_fire=0.
  - ammo=0, score=0, round_num=1, duck_cnt=0, hits=0, timer=0.
- Click → `shot_fire`, ammo and score update: 1 cycle (registered in the cycle after the edge).
- State changes 1 cycle after its trigger cycle.
- `duck_respawn` is high in the first cycle that game_state=2.
- Timed states: exit in the cycle after the N-th `new_frame` counted inside the state.
- Simultaneous click and FLY timer done in one cycle: the shot is processed.
  - Hit → FALL.
  - Miss → ESCAPE; `shot_fire` still pulses and ammo still decrements.
- Click while `mouse_left` is held: one edge only, so one shot.
- Clicks in START, FALL, ESCAPE and ROUND_END: ignored.
- Transition cycles leave no stale timer count; the counter restarts at 0 in every new state.
- Asserting reset mid-state: immediate return to reset values, no pulses emitted.

## Test plan
- Reset, then a click with `START_FRAMES`=4 and `FLY_FRAMES`=8:
  - game_state goes 0→1.
  - After 4 frames: game_state=2, one `duck_respawn` pulse, ammo=3, duck_en=1.
- FLY with `duck_hit`=1, one click:
  - `shot_fire` 1 cycle later, ammo=2, score=1, game_state=3.
  - After `ANIM_FRAMES`: duck_cnt=1, game_state=2, ammo=3.
- FLY with `duck_hit`=0, three clicks then a fourth:
  - Three `shot_fire` pulses, ammo 3→2→1→0.
  - game_state=4 after the third click; the fourth click produces no pulse.
- FLY with no clicks: exactly `FLY_FRAMES` `new_frame` pulses → game_state=4, score unchanged.
- Full round with `DUCKS_PER_ROUND`=2 and `MIN_HITS`=1:
  - One hit → ROUND_END then START, round_num=2, duck_cnt=0.
  - Zero hits → game_state=6; then a click → IDLE with score=0, round_num=1.
- Click and the final FLY `new_frame` in the same cycle with `duck_hit`=1 → FALL and score+1.
- Asynchronous reset asserted mid-FALL → all outputs at reset values.
